rr_hold_arbiter: RTL and testbench

//   Registered round-robin arbiter that shares one multi-cycle resource (bus port, memory

---
 rtl/rr_hold_arbiter.sv | 119 +++++++++++
 tb/tb_rr_hold_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with grant hold until owner release.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_hold_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WIDTH-1:0]                      req,
  // 'release' is a reserved word in SystemVerilog, so the owner-done input is named owner_release.
  input  logic                                  owner_release,
  output logic [WIDTH-1:0]                      grant,
  output logic [(WIDTH > 1 ? $clog2(WIDTH) : 1)-1:0] grant_id,
  output logic                                  busy,
  output logic                                  timeout
);

  localparam int GW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] base, base_nxt;
  logic [WIDTH-1:0] grant_nxt;
  logic [WIDTH-1:0] rot;
  logic [GW-1:0]    id_nxt;
  logic             do_rel;
  logic             load;
  logic             force_rel;

  // Fixed-priority pick starting at one-hot b, scanning upward with wrap.
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] d, m;
    d = {r, r};
    m = d & (~d + {{WIDTH{1'b0}}, b});
    return m[WIDTH-1:0] | m[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) r[(i + 1) % WIDTH] = g[i];
    return r;
  endfunction

  assign rot    = rotl1(grant);
  assign do_rel = (state == BUSY) && (owner_release || force_rel);

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    grant_nxt = grant;
    load      = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        grant_nxt = pick(req, base);
        state_nxt = BUSY;
        load      = 1'b1;
      end
    end else if (do_rel) begin
      base_nxt  = rot;
      grant_nxt = pick(req, rot);
      state_nxt = (|grant_nxt) ? BUSY : IDLE;
      load      = 1'b1;
    end
  end

  always_comb begin
    id_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (grant_nxt[i]) id_nxt = GW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= WIDTH'(1);
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      grant    <= grant_nxt;
      grant_id <= id_nxt;
      busy     <= |grant_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;

  logic [CW-1:0] hold_cnt;
  logic          timeout_q;

  // A real release in the same cycle wins, so force only fires when owner_release is low.
  assign force_rel = (state == BUSY) && !owner_release && (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (load)
        hold_cnt <= '0;
      else if (state == BUSY)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed, table-driven bench for rr_hold_arbiter (WIDTH=4, MAX_HOLD=8).
module tb_rr_hold_arbiter;

  localparam int W  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] req = '0;
  logic         rel = 1'b0;
  logic [W-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  rr_hold_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .owner_release(rel),
    .grant        (grant),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] req;
    logic         rel;
    logic [W-1:0] g;
    logic [1:0]   id;
    logic         b;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] q, input logic rl);
    rst = r; req = q; rel = rl;
    @(posedge clk);
    #1;
    chk("onehot0", -1, {31'd0, $onehot0(grant)}, 32'd1);
  endtask

  task automatic add(input logic r, input logic [W-1:0] q, input logic rl,
                     input logic [W-1:0] g, input logic [1:0] id, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.rel = rl; v.g = g; v.id = id; v.b = b;
    vecs.push_back(v);
  endtask

  initial begin
    // reset with requests pending
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    // full rotation, release every third cycle
    add(0, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 4'b1111, 1, 4'b0010, 1, 1);
    add(0, 4'b1111, 0, 4'b0010, 1, 1);
    add(0, 4'b1111, 0, 4'b0010, 1, 1);
    add(0, 4'b1111, 1, 4'b0100, 2, 1);
    add(0, 4'b1111, 0, 4'b0100, 2, 1);
    add(0, 4'b1111, 0, 4'b0100, 2, 1);
    add(0, 4'b1111, 1, 4'b1000, 3, 1);
    add(0, 4'b1111, 0, 4'b1000, 3, 1);
    add(0, 4'b1111, 0, 4'b1000, 3, 1);
    add(0, 4'b1111, 1, 4'b0001, 0, 1);
    // rotation skips to 1000 after owner 0010 releases
    add(0, 4'b1111, 1, 4'b0010, 1, 1);
    add(0, 4'b1001, 1, 4'b1000, 3, 1);
    add(0, 4'b1001, 1, 4'b0001, 0, 1);
    // sole requester re-wins every release, then idles
    add(0, 4'b0100, 1, 4'b0100, 2, 1);
    add(0, 4'b0100, 1, 4'b0100, 2, 1);
    add(0, 4'b0100, 1, 4'b0100, 2, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    // release in IDLE leaves base at 1000
    add(0, 4'b0000, 1, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 3, 1);
    // owner drops req, grant held
    add(0, 4'b0111, 0, 4'b1000, 3, 1);
    add(0, 4'b0111, 0, 4'b1000, 3, 1);
    // reset mid-BUSY restores base to 0001
    add(1, 4'b0111, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 1, 4'b0001, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].rel);
      chk("grant",    i, {28'd0, grant},    {28'd0, vecs[i].g});
      chk("grant_id", i, {30'd0, grant_id}, {30'd0, vecs[i].id});
      chk("busy",     i, {31'd0, busy},     {31'd0, vecs[i].b});
      chk("timeout",  i, {31'd0, timeout},  32'd0);
    end

    // hold limit: owner 0001 never releases
    step(1, 4'b0011, 0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < MH; c++) begin
      step(0, 4'b0011, 0);
      chk("to_hold_grant", c, {28'd0, grant}, 32'h1);
      chk("to_hold_pulse", c, {31'd0, timeout}, 32'd0);
    end
    step(0, 4'b0011, 0);
    chk("to_force_grant", 0, {28'd0, grant}, 32'h2);
    chk("to_force_pulse", 0, {31'd0, timeout}, 32'd1);
    step(0, 4'b0011, 0);
    chk("to_after_pulse", 0, {31'd0, timeout}, 32'd0);
    chk("to_after_grant", 0, {28'd0, grant}, 32'h2);
    // real release in the 8th busy cycle wins over the forced one
    step(1, 4'b0011, 0);
    for (int c = 0; c < MH - 1; c++) step(0, 4'b0011, 0);
    step(0, 4'b0011, 0);
    chk("to_pre_grant", 0, {28'd0, grant}, 32'h1);
    step(0, 4'b0011, 1);
    chk("to_rel_grant", 0, {28'd0, grant}, 32'h2);
    chk("to_rel_pulse", 0, {31'd0, timeout}, 32'd0);
`else
    for (int c = 0; c < 3 * MH; c++) begin
      step(0, 4'b0011, 0);
      chk("hold_grant", c, {28'd0, grant}, 32'h1);
      chk("hold_pulse", c, {31'd0, timeout}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
